// File: rtl/reg_wb_queue.sv
// reg_wb_queue: write-back initiator for the multi-cycle MIPS32 datapath.
// Buffers register write requests in a small FIFO and retires one per cycle
// onto the register-file write port (W_Reg / W_data / RegWr). Operand reads
// are presented either with pending writes forwarded, or raw with a hazard flag.
// Optional feature macro: WB_BYPASS_EN (forward pending writes onto op_data,
// hazard tied low). Default build: op_data is raw regfile data, hazard raised.
module reg_wb_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic                     CLK,
    input  logic                     RST_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_reg,
    input  logic [DW-1:0]            in_data,
    input  logic                     flush,
    output logic [4:0]               W_Reg,
    output logic [DW-1:0]            W_data,
    output logic                     RegWr,
    input  logic [4:0]               rd_addr1,
    input  logic [4:0]               rd_addr2,
    input  logic [DW-1:0]            rf_data1,
    input  logic [DW-1:0]            rf_data2,
    output logic [DW-1:0]            op_data1,
    output logic [DW-1:0]            op_data2,
    output logic                     hazard,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    q_reg  [DEPTH];
    logic [DW-1:0] q_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Writes to r0 are consumed but never queued; flush blocks both sides.
    assign in_ready = (count < CW'(DEPTH)) && !flush;
    assign push     = in_valid && in_ready && (in_reg != 5'd0);
    assign pop      = (count != '0) && !flush;

    // Queue storage; carries no reset since count qualifies every entry.
    always_ff @(posedge CLK) begin
        if (push) begin
            q_reg[wr_ptr]  <= in_reg;
            q_data[wr_ptr] <= in_data;
        end
    end

    // Pointers, occupancy and the registered register-file write port.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            RegWr  <= 1'b0;
            W_Reg  <= '0;
            W_data <= '0;
        end else if (flush) begin
            // The output stage is not cleared: its write still commits.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            RegWr  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                RegWr  <= 1'b1;
                W_Reg  <= q_reg[rd_ptr];
                W_data <= q_data[rd_ptr];
            end else begin
                RegWr  <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef WB_BYPASS_EN
    logic [DW-1:0] byp1;
    logic [DW-1:0] byp2;
    logic [PW-1:0] bidx;

    // Forwarding select: output stage is oldest, later queue entries override.
    always_comb begin
        byp1 = rf_data1;
        byp2 = rf_data2;
        bidx = '0;
        if (RegWr && (W_Reg == rd_addr1)) byp1 = W_data;
        if (RegWr && (W_Reg == rd_addr2)) byp2 = W_data;
        for (int i = 0; i < DEPTH; i++) begin
            bidx = rd_ptr + PW'(i);
            if (CW'(i) < count) begin
                if (q_reg[bidx] == rd_addr1) byp1 = q_data[bidx];
                if (q_reg[bidx] == rd_addr2) byp2 = q_data[bidx];
            end
        end
    end

    assign op_data1 = (rd_addr1 == 5'd0) ? '0 : byp1;
    assign op_data2 = (rd_addr2 == 5'd0) ? '0 : byp2;
    assign hazard   = 1'b0;
`else
    logic          hit1;
    logic          hit2;
    logic [PW-1:0] hidx;

    // Pending-write match per read port over the queue and output stage.
    always_comb begin
        hit1 = RegWr && (W_Reg == rd_addr1);
        hit2 = RegWr && (W_Reg == rd_addr2);
        hidx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hidx = rd_ptr + PW'(i);
            if (CW'(i) < count) begin
                if (q_reg[hidx] == rd_addr1) hit1 = 1'b1;
                if (q_reg[hidx] == rd_addr2) hit2 = 1'b1;
            end
        end
    end

    assign op_data1 = (rd_addr1 == 5'd0) ? '0 : rf_data1;
    assign op_data2 = (rd_addr2 == 5'd0) ? '0 : rf_data2;
    assign hazard   = ((rd_addr1 != 5'd0) && hit1) || ((rd_addr2 != 5'd0) && hit2);
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// Testbench for reg_wb_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the write-back buffer.
module tb_reg_wb_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic                   CLK = 1'b0;
    logic                   RST_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [4:0]             in_reg;
    logic [DW-1:0]          in_data;
    logic                   flush;
    logic [4:0]             W_Reg;
    logic [DW-1:0]          W_data;
    logic                   RegWr;
    logic [4:0]             rd_addr1;
    logic [4:0]             rd_addr2;
    logic [DW-1:0]          rf_data1;
    logic [DW-1:0]          rf_data2;
    logic [DW-1:0]          op_data1;
    logic [DW-1:0]          op_data2;
    logic                   hazard;
    logic [$clog2(DEPTH):0] count;

    always #5 CLK = ~CLK;

    reg_wb_queue #(.DEPTH(DEPTH), .DW(DW)) dut (
        .CLK(CLK), .RST_n(RST_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
        .flush(flush),
        .W_Reg(W_Reg), .W_data(W_data), .RegWr(RegWr),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .op_data1(op_data1), .op_data2(op_data2),
        .hazard(hazard), .count(count)
    );

    // Reference model: pending queue entries plus the output stage.
    typedef struct { logic [4:0] r; logic [DW-1:0] d; } ent_t;
    ent_t          mq[$];
    logic          m_vld;
    logic [4:0]    m_wreg;
    logic [DW-1:0] m_wdata;

    int n_vec = 0;
    int n_err = 0;

    // Youngest pending write to address a: {hit, data}.
    function automatic logic [DW:0] m_find(input logic [4:0] a);
        if (a == 5'd0) return '0;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].r == a) return {1'b1, mq[i].d};
        if (m_vld && m_wreg == a) return {1'b1, m_wdata};
        return '0;
    endfunction

    function automatic logic [DW-1:0] exp_op(input logic [4:0] a, input logic [DW-1:0] rf);
        logic [DW:0] f;
        f = m_find(a);
        if (a == 5'd0) return '0;
`ifdef WB_BYPASS_EN
        return f[DW] ? f[DW-1:0] : rf;
`else
        return rf;
`endif
    endfunction

    function automatic logic exp_hazard();
`ifdef WB_BYPASS_EN
        return 1'b0;
`else
        logic [DW:0] f1;
        logic [DW:0] f2;
        f1 = m_find(rd_addr1);
        f2 = m_find(rd_addr2);
        return f1[DW] | f2[DW];
`endif
    endfunction

    function automatic logic exp_ready();
        return (mq.size() < DEPTH) && !flush;
    endfunction

    task automatic set_in(input logic v, input logic [4:0] r, input logic [DW-1:0] d, input logic f);
        in_valid = v;
        in_reg   = r;
        in_data  = d;
        flush    = f;
    endtask

    // Advance the model by one clock edge using the current inputs, then the DUT.
    task automatic tick();
        ent_t e;
        logic acc;
        if (RST_n) begin
            if (flush) begin
                mq.delete();
                m_vld = 1'b0;
            end else begin
                acc = in_valid && (mq.size() < DEPTH);
                if (mq.size() > 0) begin
                    e = mq.pop_front();
                    m_vld = 1'b1;
                    m_wreg = e.r;
                    m_wdata = e.d;
                end else begin
                    m_vld = 1'b0;
                end
                if (acc && in_reg != 5'd0) begin
                    e.r = in_reg;
                    e.d = in_data;
                    mq.push_back(e);
                end
            end
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic model_reset();
        mq.delete();
        m_vld = 1'b0;
        m_wreg = '0;
        m_wdata = '0;
    endtask

    task automatic test_reset();
        RST_n = 1'b0;
        set_in(1'b0, 5'd0, '0, 1'b0);
        rd_addr1 = '0; rd_addr2 = '0; rf_data1 = '0; rf_data2 = '0;
        model_reset();
        repeat (2) @(negedge CLK);
        RST_n = 1'b1;
        #1;
        n_vec++; if (RegWr !== 1'b0) begin n_err++; $display("FAIL reset_regwr: got %0h expected 0", RegWr); end
        n_vec++; if (W_Reg !== 5'd0) begin n_err++; $display("FAIL reset_wreg: got %0h expected 0", W_Reg); end
        n_vec++; if (W_data !== '0) begin n_err++; $display("FAIL reset_wdata: got %0h expected 0", W_data); end
        n_vec++; if (count !== '0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %0h expected 1", in_ready); end
    endtask

    task automatic test_single_write();
        set_in(1'b1, 5'd5, 32'h1234, 1'b0);
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %0h expected 1", in_ready); end
        tick();
        set_in(1'b0, 5'd0, '0, 1'b0);
        #1;
        n_vec++; if (count !== 1) begin n_err++; $display("FAIL single_count1: got %0d expected 1", count); end
        n_vec++; if (RegWr !== 1'b0) begin n_err++; $display("FAIL single_early: got %0h expected 0", RegWr); end
        tick();
        #1;
        n_vec++; if ({RegWr, W_Reg, W_data} !== {1'b1, 5'd5, 32'h1234})
            begin n_err++; $display("FAIL single_write: got %0h/%0d/%0h expected 1/5/1234", RegWr, W_Reg, W_data); end
        n_vec++; if (count !== 0) begin n_err++; $display("FAIL single_count0: got %0d expected 0", count); end
        tick();
        #1;
        n_vec++; if (RegWr !== 1'b0) begin n_err++; $display("FAIL single_pulse: got %0h expected 0", RegWr); end
    endtask

    task automatic test_back_to_back();
        ent_t sent[$];
        ent_t got[$];
        ent_t e;
        for (int c = 0; c < 10; c++) begin
            if (c < 6) begin
                e.r = 5'(c + 1);
                e.d = $urandom;
                sent.push_back(e);
                set_in(1'b1, e.r, e.d, 1'b0);
            end else begin
                set_in(1'b0, 5'd0, '0, 1'b0);
            end
            #1;
            n_vec++; if (in_ready !== exp_ready()) begin n_err++; $display("FAIL b2b_ready: got %0h expected %0h", in_ready, exp_ready()); end
            n_vec++; if (int'(count) !== mq.size()) begin n_err++; $display("FAIL b2b_count: got %0d expected %0d", count, mq.size()); end
            if (RegWr === 1'b1) begin
                e.r = W_Reg;
                e.d = W_data;
                got.push_back(e);
            end
            tick();
        end
        n_vec++; if (got.size() !== 6) begin n_err++; $display("FAIL b2b_nwrites: got %0d expected 6", got.size()); end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            n_vec++;
            if (got[i].r !== sent[i].r || got[i].d !== sent[i].d)
                begin n_err++; $display("FAIL b2b_order: got r%0d=%0h expected r%0d=%0h", got[i].r, got[i].d, sent[i].r, sent[i].d); end
        end
    endtask

    task automatic test_reg0();
        rd_addr1 = 5'd0;
        rf_data1 = 32'hDEADBEEF;
        set_in(1'b1, 5'd0, 32'hFFFF, 1'b0);
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL r0_ready: got %0h expected 1", in_ready); end
        tick();
        set_in(1'b0, 5'd0, '0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++; if (RegWr !== 1'b0) begin n_err++; $display("FAIL r0_regwr: got %0h expected 0", RegWr); end
            n_vec++; if (count !== 0) begin n_err++; $display("FAIL r0_count: got %0d expected 0", count); end
            n_vec++; if (op_data1 !== '0) begin n_err++; $display("FAIL r0_op: got %0h expected 0", op_data1); end
            tick();
        end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] want;
        rd_addr1 = 5'd3;
        rf_data1 = 32'h7;
        set_in(1'b1, 5'd3, 32'hA, 1'b0);
        tick();
        set_in(1'b1, 5'd3, 32'hB, 1'b0);
        tick();
        set_in(1'b0, 5'd0, '0, 1'b0);
        #1;
`ifdef WB_BYPASS_EN
        want = 32'hB;
`else
        want = 32'h7;
`endif
        n_vec++; if (op_data1 !== want) begin n_err++; $display("FAIL byp_young: got %0h expected %0h", op_data1, want); end
`ifndef WB_BYPASS_EN
        n_vec++; if (hazard !== 1'b1) begin n_err++; $display("FAIL byp_hazard: got %0h expected 1", hazard); end
`endif
        tick();
        tick();
        rf_data1 = 32'hB;
        #1;
        n_vec++; if (op_data1 !== 32'hB) begin n_err++; $display("FAIL byp_commit: got %0h expected b", op_data1); end
        n_vec++; if (count !== 0) begin n_err++; $display("FAIL byp_empty: got %0d expected 0", count); end
        n_vec++; if (hazard !== 1'b0) begin n_err++; $display("FAIL byp_nohaz: got %0h expected 0", hazard); end
    endtask

    task automatic test_hazard();
        logic want;
        rd_addr1 = 5'd0;
        rd_addr2 = 5'd9;
        rf_data2 = 32'h55;
        set_in(1'b1, 5'd9, 32'h99, 1'b0);
        tick();
        set_in(1'b0, 5'd0, '0, 1'b0);
`ifdef WB_BYPASS_EN
        want = 1'b0;
`else
        want = 1'b1;
`endif
        for (int c = 0; c < 2; c++) begin
            #1;
            n_vec++; if (hazard !== want) begin n_err++; $display("FAIL haz_pending: got %0h expected %0h", hazard, want); end
            n_vec++; if (op_data2 !== exp_op(rd_addr2, rf_data2)) begin n_err++; $display("FAIL haz_op: got %0h expected %0h", op_data2, exp_op(rd_addr2, rf_data2)); end
            tick();
        end
        #1;
        n_vec++; if (hazard !== 1'b0) begin n_err++; $display("FAIL haz_drop: got %0h expected 0", hazard); end
    endtask

    task automatic test_flush();
        set_in(1'b1, 5'd1, 32'h11, 1'b0);
        tick();
        set_in(1'b1, 5'd2, 32'h22, 1'b0);
        tick();
        set_in(1'b1, 5'd3, 32'h33, 1'b1);
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %0h expected 0", in_ready); end
        n_vec++; if ({RegWr, W_Reg} !== {1'b1, 5'd1}) begin n_err++; $display("FAIL flush_commit: got %0h/%0d expected 1/1", RegWr, W_Reg); end
        tick();
        set_in(1'b0, 5'd0, '0, 1'b0);
        #1;
        n_vec++; if (count !== 0) begin n_err++; $display("FAIL flush_count: got %0d expected 0", count); end
        for (int c = 0; c < 3; c++) begin
            n_vec++; if (RegWr !== 1'b0) begin n_err++; $display("FAIL flush_drop: got %0h/r%0d expected 0", RegWr, W_Reg); end
            tick();
            #1;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            set_in($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 15) == 0);
            rd_addr1 = 5'($urandom_range(0, 7));
            rd_addr2 = 5'($urandom_range(0, 7));
            rf_data1 = $urandom;
            rf_data2 = $urandom;
            #1;
            n_vec++; if (in_ready !== exp_ready()) begin n_err++; $display("FAIL rnd_ready: got %0h expected %0h", in_ready, exp_ready()); end
            n_vec++; if (int'(count) !== mq.size()) begin n_err++; $display("FAIL rnd_count: got %0d expected %0d", count, mq.size()); end
            n_vec++; if (RegWr !== m_vld) begin n_err++; $display("FAIL rnd_regwr: got %0h expected %0h", RegWr, m_vld); end
            n_vec++; if ({W_Reg, W_data} !== {m_wreg, m_wdata}) begin n_err++; $display("FAIL rnd_wport: got %0d/%0h expected %0d/%0h", W_Reg, W_data, m_wreg, m_wdata); end
            n_vec++; if (op_data1 !== exp_op(rd_addr1, rf_data1)) begin n_err++; $display("FAIL rnd_op1: got %0h expected %0h", op_data1, exp_op(rd_addr1, rf_data1)); end
            n_vec++; if (op_data2 !== exp_op(rd_addr2, rf_data2)) begin n_err++; $display("FAIL rnd_op2: got %0h expected %0h", op_data2, exp_op(rd_addr2, rf_data2)); end
            n_vec++; if (hazard !== exp_hazard()) begin n_err++; $display("FAIL rnd_hazard: got %0h expected %0h", hazard, exp_hazard()); end
            tick();
        end
    endtask

    task automatic test_reset_midop();
        set_in(1'b1, 5'd4, 32'h44, 1'b0);
        tick();
        set_in(1'b1, 5'd6, 32'h66, 1'b0);
        tick();
        set_in(1'b0, 5'd0, '0, 1'b0);
        #2;
        RST_n = 1'b0;
        model_reset();
        #1;
        n_vec++; if ({RegWr, W_Reg, W_data} !== '0) begin n_err++; $display("FAIL midrst_wport: got %0h/%0d/%0h expected 0/0/0", RegWr, W_Reg, W_data); end
        n_vec++; if (count !== 0) begin n_err++; $display("FAIL midrst_count: got %0d expected 0", count); end
        @(negedge CLK);
        RST_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++; if (RegWr !== 1'b0) begin n_err++; $display("FAIL midrst_nowrite: got %0h expected 0", RegWr); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_reg0();
        test_bypass();
        test_hazard();
        test_flush();
        test_random();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
